// File: rtl/ecc_parity_encoder.sv
// SECDED parity encoder: S1 masks the data and forms the Hamming bits,
// S2 adds the overall parity bit and assembles the 8/16/32-bit codeword.
module ecc_parity_encoder #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 32,
    parameter int AMBA_WORD       = 32,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            cw_width,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            parity_out,
    output logic [DATA_WIDTH-1:0] cw_out,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  enc_count
);

    // Handshake: a word moves into a stage when that stage is empty or is
    // itself draining this cycle; every stage holds its contents otherwise.
    localparam logic [1:0] W_S = 2'd0;
    localparam logic [1:0] W_M = 2'd1;
    localparam logic [1:0] W_L = 2'd2;

    logic                 s1_valid_q, s1_valid_d;
    logic [1:0]           s1_width_q, s1_width_d;
    logic [25:0]          s1_data_q, s1_data_d;
    logic [4:0]           s1_p_q, s1_p_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [5:0]           parity_q, parity_d;
    logic [31:0]          cw_q, cw_d;
    logic [CNT_WIDTH-1:0] enc_count_q, enc_count_d;

    logic        in_fire, out_fire, s2_free, s1_move;
    logic [1:0]  width_sel;
    logic [25:0] data_masked;
    logic        po;
    logic        unused_sig;

    // Data bit j uses column code c(j): the j-th value >= 3 that is not a power of two.
    function automatic logic [4:0] hamming(input logic [25:0] d);
        logic [4:0] p;
        logic [4:0] j;
        logic [4:0] code;
        p = '0;
        for (int i = 0; i < 5; i++) begin
            j = '0;
            for (int v = 3; v < 32; v++) begin
                if ((v & (v - 1)) != 0) begin
                    code = 5'(v);
                    if (code[i[2:0]]) p[i[2:0]] = p[i[2:0]] ^ d[j];
                    j = j + 5'd1;
                end
            end
        end
        return p;
    endfunction

    assign unused_sig = ^{data_in[DATA_WIDTH-1:26], 1'(AMBA_ADDR_WIDTH & 1), 1'(AMBA_WORD & 1)};

    assign s2_free  = ~s2_valid_q | out_ready;
    assign s1_move  = s1_valid_q & s2_free;
    assign in_ready = ~s1_valid_q | ~s2_valid_q | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = s2_valid_q & out_ready;

    always_comb begin
        width_sel   = (cw_width == 2'd3) ? W_L : cw_width;
        data_masked = data_in[25:0];
        case (width_sel)
            W_S:     data_masked = {22'b0, data_in[3:0]};
            W_M:     data_masked = {15'b0, data_in[10:0]};
            default: data_masked = data_in[25:0];
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_width_d = s1_width_q;
        s1_data_d  = s1_data_q;
        s1_p_d     = s1_p_q;
        if (s1_move) s1_valid_d = 1'b0;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_width_d = width_sel;
            s1_data_d  = data_masked;
            s1_p_d     = hamming(data_masked);
        end
    end

    // Upper Hamming bits are naturally zero for S/M, so the full XOR is safe.
    assign po = (^s1_data_q) ^ (^s1_p_q);

    always_comb begin
        s2_valid_d = s2_valid_q;
        parity_d   = parity_q;
        cw_d       = cw_q;
        if (s2_free) s2_valid_d = s1_valid_q;
        if (s1_move) begin
            case (s1_width_q)
                W_S: begin
                    parity_d = {2'b0, po, s1_p_q[2:0]};
                    cw_d     = {24'b0, po, s1_p_q[2:0], s1_data_q[3:0]};
                end
                W_M: begin
                    parity_d = {1'b0, po, s1_p_q[3:0]};
                    cw_d     = {16'b0, po, s1_p_q[3:0], s1_data_q[10:0]};
                end
                default: begin
                    parity_d = {po, s1_p_q};
                    cw_d     = {po, s1_p_q, s1_data_q};
                end
            endcase
        end
    end

    always_comb begin
        enc_count_d = enc_count_q;
        if (cnt_clr) enc_count_d = '0;
        else if (out_fire && !(&enc_count_q)) enc_count_d = enc_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_width_q  <= 2'd0;
            s1_data_q   <= '0;
            s1_p_q      <= '0;
            s2_valid_q  <= 1'b0;
            parity_q    <= '0;
            cw_q        <= '0;
            enc_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_width_q  <= s1_width_d;
            s1_data_q   <= s1_data_d;
            s1_p_q      <= s1_p_d;
            s2_valid_q  <= s2_valid_d;
            parity_q    <= parity_d;
            cw_q        <= cw_d;
            enc_count_q <= enc_count_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign parity_out = parity_q;
    assign cw_out     = DATA_WIDTH'(cw_q);
    assign enc_count  = enc_count_q;

endmodule

// File: tb/tb_ecc_parity_encoder.sv
// Bench for ecc_parity_encoder: directed vectors, backpressure, reset flush,
// counter clear/saturation and random traffic against a reference model.
module tb_ecc_parity_encoder;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic [1:0]    cw_width;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_in;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    parity_out;
    logic [DW-1:0] cw_out;
    logic          cnt_clr;
    logic [CW-1:0] enc_count;

    ecc_parity_encoder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .cw_width(cw_width), .in_valid(in_valid),
        .in_ready(in_ready), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .parity_out(parity_out), .cw_out(cw_out),
        .cnt_clr(cnt_clr), .enc_count(enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          exp_cnt = 0;
    logic [37:0] exp_q[$];
    logic        rand_ready = 1'b0;
    logic        ready_val = 1'b1;
    logic        held_valid = 1'b0;
    logic [37:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: parity bits are the XOR of the column codes of all set data bits.
    function automatic logic [37:0] model(input logic [1:0] w, input logic [31:0] d);
        int          k, h, v;
        logic [31:0] dm, cwv;
        logic [4:0]  p;
        logic [5:0]  par;
        logic        pov;
        k  = (w == 2'd0) ? 4 : (w == 2'd1) ? 11 : 26;
        h  = (w == 2'd0) ? 3 : (w == 2'd1) ? 4 : 5;
        dm = d & ((32'h1 << k) - 32'h1);
        p  = '0;
        v  = 2;
        for (int j = 0; j < k; j++) begin
            v++;
            while ((v & (v - 1)) == 0) v++;
            if (((dm >> j) & 32'h1) != 0) p = p ^ 5'(v);
        end
        pov = (^dm) ^ (^p);
        cwv = dm | (32'(p) << k) | (32'(pov) << (k + h));
        par = 6'(p) | (6'(pov) << h);
        return {par, cwv};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? ($urandom_range(0, 99) < 70) : ready_val;
        end
    end

    // Monitor: checks count, stall stability and every delivered word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_cnt    = 0;
                held_valid = 1'b0;
            end else begin
                check("enc_count", 64'(enc_count), 64'(exp_cnt));
                if (held_valid)
                    check("stall_hold", {out_valid, parity_out, cw_out}, {1'b1, held});
                held_valid = 1'b0;
                if (out_valid) begin
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_output", {parity_out, cw_out}, 64'hDEAD);
                        end else begin
                            check("word", {parity_out, cw_out}, exp_q.pop_front());
                        end
                    end else begin
                        held       = {parity_out, cw_out};
                        held_valid = 1'b1;
                    end
                end
                if (cnt_clr) exp_cnt = 0;
                else if (out_valid && out_ready && exp_cnt != (1 << CW) - 1) exp_cnt++;
            end
        end
    end

    task automatic send(input logic [1:0] w, input logic [31:0] d, input logic [37:0] exp);
        int   cyc = 0;
        logic acc = 1'b0;
        cw_width = w;
        data_in  = d;
        in_valid = 1'b1;
        while (!acc && cyc < 1000) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                exp_q.push_back(exp);
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [1:0]  bp_w[4];
    logic [31:0] bp_d[4];
    int          acc_n;
    logic [1:0]  rw;
    logic [31:0] rd;

    initial begin
        rst = 1'b1; in_valid = 1'b0; cw_width = 2'd0; data_in = '0; cnt_clr = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_parity", 64'(parity_out), 64'd0);
        check("rst_cw", 64'(cw_out), 64'd0);
        check("rst_count", 64'(enc_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        idle(3);
        rst = 1'b0;
        idle(2);

        // Directed vectors with hand-derived expectations.
        send(2'd0, 32'h1,        {6'h0B, 32'h000000B1});
        send(2'd0, 32'hF,        {6'h0F, 32'h000000FF});
        send(2'd0, 32'hFFFFFFF0, {6'h00, 32'h00000000});
        send(2'd1, 32'h001,      {6'h13, 32'h00009801});
        send(2'd2, 32'h3FFFFFF,  {6'h3F, 32'hFFFFFFFF});
        send(2'd3, 32'hFC000000, {6'h00, 32'h00000000});
        drain();

        // Two-cycle latency with an empty pipeline.
        send(2'd1, 32'h5A5, model(2'd1, 32'h5A5));
        @(negedge clk);
        check("latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_c2", 64'(out_valid), 64'd1);
        drain();

        // Backpressure: two words fill the pipe, then in_ready drops.
        ready_val = 1'b0;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            bp_w[i] = 2'($urandom_range(0, 2));
            bp_d[i] = $urandom;
        end
        acc_n = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (acc_n < 4);
            cw_width = bp_w[acc_n % 4];
            data_in  = bp_d[acc_n % 4];
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(bp_w[acc_n], bp_d[acc_n]));
                acc_n++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", 64'(acc_n), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        ready_val = 1'b1;
        for (int i = 2; i < 4; i++) send(bp_w[i], bp_d[i], model(bp_w[i], bp_d[i]));
        drain();

        // cnt_clr coincides with an output transfer: clear wins.
        send(2'd2, 32'h0123456, model(2'd2, 32'h0123456));
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("clr_wins", 64'(enc_count), 64'd0);
        drain();

        // Reset with both stages full flushes everything.
        ready_val = 1'b0;
        idle(2);
        send(2'd0, 32'h3, model(2'd0, 32'h3));
        send(2'd1, 32'h7FF, model(2'd1, 32'h7FF));
        @(negedge clk);
        check("full_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_count", 64'(enc_count), 64'd0);
        check("rst_mid_cw", 64'(cw_out), 64'd0);
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        ready_val = 1'b1;
        idle(6);
        check("flushed_no_out", 64'(out_valid), 64'd0);

        // Random traffic with random backpressure.
        rand_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            rw = 2'($urandom_range(0, 3));
            rd = $urandom;
            send(rw, rd, model(rw, rd));
            if ($urandom_range(0, 99) < 20) idle($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        idle(2);
        drain();
        check("count_saturated", 64'(enc_count), 64'((1 << CW) - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
